// File: rtl/pcie_hcmd_prp_store_if.sv
// Write/free/read bundle between the PRP parser (master) and the PRP entry store (slave).
// Pure wiring: no storage, and no backpressure in either direction.
interface pcie_hcmd_prp_store_if #(
  parameter int P_SLOT_TAG_WIDTH  = 10,
  parameter int P_ENTRY_SEL_WIDTH = 1,
  parameter int P_DATA_WIDTH      = 54
);
  localparam int P_ADDR_WIDTH = P_SLOT_TAG_WIDTH + P_ENTRY_SEL_WIDTH;

  logic                        wr_en;
  logic [P_ADDR_WIDTH-1:0]     wr_addr;
  logic [P_DATA_WIDTH-1:0]     wr_data;
  logic                        free_en;
  logic [P_SLOT_TAG_WIDTH-1:0] free_slot_tag;
  logic                        rd_req;
  logic [P_ADDR_WIDTH-1:0]     rd_addr;
  logic                        rd_valid;
  logic                        rd_hit;
  logic [P_DATA_WIDTH-1:0]     rd_data;
  logic [P_ADDR_WIDTH:0]       valid_cnt;

  modport master (
    output wr_en, wr_addr, wr_data, free_en, free_slot_tag, rd_req, rd_addr,
    input  rd_valid, rd_hit, rd_data, valid_cnt
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, free_en, free_slot_tag, rd_req, rd_addr,
    output rd_valid, rd_hit, rd_data, valid_cnt
  );
endinterface

// File: rtl/pcie_hcmd_prp_store.sv
// PRP entry store: per-slot PRP words with valid bits, slot release and a pipelined read port.
// Read latency P_RD_LATENCY (1 or 2) cycles; writes, frees and reads are always accepted.
module pcie_hcmd_prp_store #(
  parameter int P_SLOT_TAG_WIDTH  = 10,
  parameter int P_ENTRY_SEL_WIDTH = 1,
  parameter int P_DATA_WIDTH      = 54,
  parameter int P_RD_LATENCY      = 1,
  parameter bit P_BYPASS          = 1'b1
) (
  input  logic                   pcie_user_clk,
  input  logic                   pcie_user_rst_n,
  pcie_hcmd_prp_store_if.slave   bus
);
  localparam int P_ADDR_WIDTH = P_SLOT_TAG_WIDTH + P_ENTRY_SEL_WIDTH;
  localparam int P_DEPTH      = 1 << P_ADDR_WIDTH;
  localparam int P_ENTRIES    = 1 << P_ENTRY_SEL_WIDTH;
  localparam int P_CNT_WIDTH  = P_ADDR_WIDTH + 1;
  localparam logic [P_CNT_WIDTH:0] P_CNT_MAX = (P_CNT_WIDTH + 1)'(P_DEPTH);

  logic [P_DATA_WIDTH-1:0] mem [P_DEPTH];
  logic [P_DEPTH-1:0]      valid_q;
  logic [P_DEPTH-1:0]      valid_d;
  logic [P_CNT_WIDTH-1:0]  cnt_q;
  logic [P_CNT_WIDTH-1:0]  cnt_d;
  logic [P_CNT_WIDTH-1:0]  freed;
  logic [P_CNT_WIDTH:0]    cnt_up;
  logic [P_ADDR_WIDTH-1:0] free_ent;
  logic                    wr_new;

  // Array contents are deliberately left unreset; only the valid bits carry state.
  always_ff @(posedge pcie_user_clk) begin
    if (bus.wr_en) begin
      mem[bus.wr_addr] <= bus.wr_data;
    end
  end

  // Free clears the slot first, then the write re-sets its own entry.
  always_comb begin
    valid_d  = valid_q;
    freed    = '0;
    free_ent = '0;
    if (bus.free_en) begin
      for (int e = 0; e < P_ENTRIES; e++) begin
        free_ent = {bus.free_slot_tag, P_ENTRY_SEL_WIDTH'(e)};
        if (valid_q[free_ent] && !(bus.wr_en && (bus.wr_addr == free_ent))) begin
          freed = freed + 1'b1;
        end
        valid_d[free_ent] = 1'b0;
      end
    end
    if (bus.wr_en) begin
      valid_d[bus.wr_addr] = 1'b1;
    end
  end

  // A write to an already-valid entry that also sits in the freed slot is excluded
  // from 'freed', so it nets to zero; a fresh entry always adds one.
  assign wr_new = bus.wr_en & ~valid_q[bus.wr_addr];

  always_comb begin
    cnt_up = {1'b0, cnt_q} + {{P_CNT_WIDTH{1'b0}}, wr_new};
    if (cnt_up > P_CNT_MAX) begin
      cnt_up = P_CNT_MAX;
    end
    if ({1'b0, freed} >= cnt_up) begin
      cnt_d = '0;
    end else begin
      cnt_d = P_CNT_WIDTH'(cnt_up - {1'b0, freed});
    end
  end

  always_ff @(posedge pcie_user_clk) begin
    if (!pcie_user_rst_n) begin
      valid_q <= '0;
      cnt_q   <= '0;
    end else begin
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.valid_cnt = cnt_q;

  logic                    rd_fwd;
  logic                    s1_vld;
  logic                    s1_hit;
  logic [P_DATA_WIDTH-1:0] s1_dat;
  logic                    out_vld;
  logic                    out_hit;
  logic [P_DATA_WIDTH-1:0] out_dat;

  assign rd_fwd = P_BYPASS && bus.wr_en && (bus.wr_addr == bus.rd_addr);

  // Valid bit is sampled pre-update, so a same-cycle free is seen read-first.
  always_ff @(posedge pcie_user_clk) begin
    if (!pcie_user_rst_n) begin
      s1_vld <= 1'b0;
      s1_hit <= 1'b0;
      s1_dat <= '0;
    end else begin
      s1_vld <= bus.rd_req;
      if (bus.rd_req) begin
        s1_hit <= rd_fwd ? 1'b1        : valid_q[bus.rd_addr];
        s1_dat <= rd_fwd ? bus.wr_data : mem[bus.rd_addr];
      end
    end
  end

  generate
    if (P_RD_LATENCY >= 2) begin : g_lat2
      logic                    s2_vld;
      logic                    s2_hit;
      logic [P_DATA_WIDTH-1:0] s2_dat;

      always_ff @(posedge pcie_user_clk) begin
        if (!pcie_user_rst_n) begin
          s2_vld <= 1'b0;
          s2_hit <= 1'b0;
          s2_dat <= '0;
        end else begin
          s2_vld <= s1_vld;
          if (s1_vld) begin
            s2_hit <= s1_hit;
            s2_dat <= s1_dat;
          end
        end
      end

      assign out_vld = s2_vld;
      assign out_hit = s2_hit;
      assign out_dat = s2_dat;
    end else begin : g_lat1
      assign out_vld = s1_vld;
      assign out_hit = s1_hit;
      assign out_dat = s1_dat;
    end
  endgenerate

  assign bus.rd_valid = out_vld;
  assign bus.rd_hit   = out_vld & out_hit;
  assign bus.rd_data  = out_vld ? out_dat : '0;
endmodule

// File: tb/tb_pcie_hcmd_prp_store.sv
// Drives two store instances (latency 1 + bypass, latency 2 + no bypass) with the same
// stimulus and compares both against an array/queue model of the store's rules.
module tb_pcie_hcmd_prp_store;
  localparam int ST    = 10;
  localparam int ES    = 1;
  localparam int DW    = 54;
  localparam int AW    = ST + ES;
  localparam int DEPTH = 1 << AW;
  localparam int NENT  = 1 << ES;

  typedef struct {
    int             due;
    bit             hit;
    logic [DW-1:0]  dat;
  } rsp_t;

  logic pcie_user_clk = 1'b0;
  logic pcie_user_rst_n;
  always #5 pcie_user_clk = ~pcie_user_clk;

  pcie_hcmd_prp_store_if #(.P_SLOT_TAG_WIDTH(ST), .P_ENTRY_SEL_WIDTH(ES), .P_DATA_WIDTH(DW)) ifa ();
  pcie_hcmd_prp_store_if #(.P_SLOT_TAG_WIDTH(ST), .P_ENTRY_SEL_WIDTH(ES), .P_DATA_WIDTH(DW)) ifb ();

  pcie_hcmd_prp_store #(.P_SLOT_TAG_WIDTH(ST), .P_ENTRY_SEL_WIDTH(ES), .P_DATA_WIDTH(DW),
                        .P_RD_LATENCY(1), .P_BYPASS(1'b1)) dut_a (
    .pcie_user_clk(pcie_user_clk), .pcie_user_rst_n(pcie_user_rst_n), .bus(ifa));

  pcie_hcmd_prp_store #(.P_SLOT_TAG_WIDTH(ST), .P_ENTRY_SEL_WIDTH(ES), .P_DATA_WIDTH(DW),
                        .P_RD_LATENCY(2), .P_BYPASS(1'b0)) dut_b (
    .pcie_user_clk(pcie_user_clk), .pcie_user_rst_n(pcie_user_rst_n), .bus(ifb));

  logic [DW-1:0] m_mem [DEPTH];
  bit            m_vld [DEPTH];
  int            m_cnt;
  int            cyc;
  int            errors;
  int            checks;
  rsp_t          qa[$];
  rsp_t          qb[$];

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  task automatic check_rsp(input string p, input logic v, input logic h, input logic [DW-1:0] d,
                           input bit ev, input rsp_t r);
    check({p, "_vld"}, 64'(v), 64'(ev));
    if (ev) begin
      check({p, "_hit"}, 64'(h), 64'(r.hit));
      if (r.hit) check({p, "_dat"}, 64'(d), 64'(r.dat));
    end else begin
      check({p, "_hit_idle"}, 64'(h), 64'd0);
      check({p, "_dat_idle"}, 64'(d), 64'd0);
    end
  endtask

  // One clock: apply inputs, predict responses, advance the model, check both instances.
  task automatic step(input bit wr, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                      input bit fr, input logic [ST-1:0] ft,
                      input bit rq, input logic [AW-1:0] ra, input bit rn);
    rsp_t r;
    bit   ev;
    pcie_user_rst_n   = rn;
    ifa.wr_en         = wr;  ifb.wr_en         = wr;
    ifa.wr_addr       = wa;  ifb.wr_addr       = wa;
    ifa.wr_data       = wd;  ifb.wr_data       = wd;
    ifa.free_en       = fr;  ifb.free_en       = fr;
    ifa.free_slot_tag = ft;  ifb.free_slot_tag = ft;
    ifa.rd_req        = rq;  ifb.rd_req        = rq;
    ifa.rd_addr       = ra;  ifb.rd_addr       = ra;
    if (rn && rq) begin
      r.due = cyc + 1;
      r.hit = (wr && wa == ra) ? 1'b1 : m_vld[ra];
      r.dat = (wr && wa == ra) ? wd : m_mem[ra];
      qa.push_back(r);
      r.due = cyc + 2;
      r.hit = m_vld[ra];
      r.dat = m_mem[ra];
      qb.push_back(r);
    end
    @(posedge pcie_user_clk);
    cyc++;
    if (!rn) begin
      for (int i = 0; i < DEPTH; i++) m_vld[i] = 1'b0;
      qa.delete();
      qb.delete();
    end else begin
      if (fr) for (int e = 0; e < NENT; e++) m_vld[{ft, ES'(e)}] = 1'b0;
      if (wr) begin
        m_mem[wa] = wd;
        m_vld[wa] = 1'b1;
      end
    end
    m_cnt = 0;
    for (int i = 0; i < DEPTH; i++) m_cnt += int'(m_vld[i]);
    #1;
    ev = (qa.size() > 0) && (qa[0].due == cyc);
    r  = ev ? qa.pop_front() : '{0, 1'b0, '0};
    check_rsp("a", ifa.rd_valid, ifa.rd_hit, ifa.rd_data, ev, r);
    ev = (qb.size() > 0) && (qb[0].due == cyc);
    r  = ev ? qb.pop_front() : '{0, 1'b0, '0};
    check_rsp("b", ifb.rd_valid, ifb.rd_hit, ifb.rd_data, ev, r);
    check("a_cnt", 64'(ifa.valid_cnt), 64'(m_cnt));
    check("b_cnt", 64'(ifb.valid_cnt), 64'(m_cnt));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, '0, '0, 0, '0, 0, '0, 1);
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    step(1, a, d, 0, '0, 0, '0, 1);
  endtask

  task automatic rd(input logic [AW-1:0] a);
    step(0, '0, '0, 0, '0, 1, a, 1);
  endtask

  function automatic logic [DW-1:0] rnd_dat();
    logic [63:0] v;
    v = {$urandom(), $urandom()};
    return v[DW-1:0];
  endfunction

  initial begin
    errors = 0;
    checks = 0;
    cyc    = 0;
    for (int i = 0; i < DEPTH; i++) begin
      m_vld[i] = 1'b0;
      m_mem[i] = '0;
    end
    step(0, '0, '0, 0, '0, 0, '0, 0);
    step(0, '0, '0, 0, '0, 1, 11'h005, 0);
    idle(3);
    check("rst_cnt", 64'(ifa.valid_cnt), 64'd0);

    // Basic write/read and a miss on an unwritten entry.
    wr(11'h005, 54'h2A_BCDE_F012);
    check("t1_cnt", 64'(ifa.valid_cnt), 64'd1);
    rd(11'h005);
    rd(11'h006);
    idle(3);

    // Same-cycle write and read of one address.
    wr(11'h010, 54'h222);
    step(1, 11'h010, 54'h111, 0, '0, 1, 11'h010, 1);
    idle(3);

    // Free slot 4 while rewriting entry 1 of it.
    wr(11'h008, 54'h8888);
    wr(11'h009, 54'h9999);
    step(1, 11'h009, 54'h1_2345, 1, 10'h004, 0, '0, 1);
    check("t4_cnt", 64'(ifa.valid_cnt), 64'd3);
    rd(11'h008);
    rd(11'h009);
    idle(3);

    // Rewriting a valid entry keeps the count and returns the last data.
    for (int i = 0; i < 3; i++) wr(11'h020, 54'h300 + DW'(i));
    check("t6_cnt", 64'(ifa.valid_cnt), 64'd4);
    rd(11'h020);
    idle(3);

    // 16 back-to-back reads, then reset in the middle of a second stream.
    for (int i = 0; i < 16; i++) rd(AW'($urandom_range(0, 63)));
    for (int i = 0; i < 5; i++) rd(AW'($urandom_range(0, 63)));
    step(0, '0, '0, 0, '0, 1, 11'h005, 0);
    check("mid_rst_vld", 64'(ifb.rd_valid), 64'd0);
    idle(4);

    // Fill every entry, then release the last slot.
    for (int i = 0; i < DEPTH; i++) wr(AW'(i), rnd_dat());
    check("fill_cnt", 64'(ifa.valid_cnt), 64'(DEPTH));
    step(0, '0, '0, 1, 10'h3FF, 0, '0, 1);
    check("free_cnt", 64'(ifa.valid_cnt), 64'(DEPTH - 2));
    rd(11'h7FE);
    rd(11'h7FF);
    rd(11'h7FD);
    idle(3);

    // Random traffic concentrated on a few slots so collisions are common.
    for (int i = 0; i < 3000; i++) begin
      logic [AW-1:0] wa;
      logic [AW-1:0] ra;
      logic [ST-1:0] ft;
      bit            rn;
      wa = AW'($urandom_range(0, 15));
      ra = ($urandom_range(0, 3) == 0) ? wa : AW'($urandom_range(0, 15));
      ft = ($urandom_range(0, 1) == 0) ? wa[AW-1:ES] : ST'($urandom_range(0, 7));
      rn = ($urandom_range(0, 199) != 0);
      step(rn && ($urandom_range(0, 1) == 1), wa, rnd_dat(),
           rn && ($urandom_range(0, 7) == 0), ft,
           $urandom_range(0, 1) == 1, ra, rn);
    end
    idle(4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
